// File: rtl/elem_streamer_pkg.sv
// Shared types for the element streamer: FSM state encoding and the FIFO entry tag.
// The tag travels alongside each buffered element so the consumer knows its index and range end.
package elem_streamer_pkg;

    localparam int IDX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             last;
    } elem_tag_t;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/elem_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module elem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;
    // Head is zeroed while empty so the stream outputs read zero with nothing to present.
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/elem_streamer.sv
// Walks an index range, issuing one read at a time to the element reader, and buffers the
// returned elements so downstream stalls never back up into the (non-stallable) reader.
module elem_streamer
    import elem_streamer_pkg::*;
#(
    parameter int NDWORDS    = 9,
    parameter int ELEMSZ     = 32 * NDWORDS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       first_index,
    input  logic [31:0]       count,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rd_index,
    output logic              rd_read,
    input  logic              rd_iready,
    input  logic [ELEMSZ-1:0] rd_data,
    input  logic              rd_ovalid,
    output logic [ELEMSZ-1:0] out_data,
    output logic [31:0]       out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TAG_W   = $bits(elem_tag_t);
    localparam int ENTRY_W = ELEMSZ + TAG_W;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_next_idx;
    logic [31:0]       r_remaining;
    logic [31:0]       r_tag_idx;

    logic              w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_drain_done;
    elem_tag_t         w_in_tag;
    elem_tag_t         w_out_tag;
    logic [ENTRY_W-1:0] w_pop_entry;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // A request is only issued when the FIFO has room for its response, so a push can never
    // be lost even though the reader cannot be stalled once it has accepted a request.
    assign w_credit     = (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_issue      = (r_state == ISSUE) && rd_iready && w_credit;
    assign w_push       = (r_state == WAIT) && rd_ovalid && !w_fifo_full;
    assign w_pop        = !w_fifo_empty && out_ready;
    assign w_drain_done = (r_state == DRAIN) && w_fifo_empty;

    assign w_in_tag.index = r_tag_idx;
    assign w_in_tag.last  = (r_remaining == '0);
    assign w_out_tag      = w_pop_entry[TAG_W-1:0];

    elem_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({rd_data, w_in_tag}),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (rd_ovalid) begin
                    w_next_state = (r_remaining != '0) ? ISSUE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE) && !w_drain_done;
        done      = w_drain_done;
        rd_read   = w_issue;
        rd_index  = r_next_idx;
        out_valid = !w_fifo_empty;
        out_data  = w_pop_entry[ENTRY_W-1:TAG_W];
        out_index = w_out_tag.index;
        out_last  = w_out_tag.last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_idx  <= '0;
            r_remaining <= '0;
            r_tag_idx   <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_next_idx  <= first_index;
            r_remaining <= count;
        end else if (w_issue) begin
            r_next_idx  <= idx_inc(r_next_idx);
            r_remaining <= r_remaining - 1'b1;
            r_tag_idx   <= r_next_idx;
        end
    end

endmodule

// File: tb/tb_elem_streamer.sv
// Directed bench for elem_streamer: a latency-configurable reader model, a negedge monitor,
// and one task per scenario with hand-computed expectations.
module tb_elem_streamer;

    localparam int NDWORDS = 9;
    localparam int ELEMSZ  = 32 * NDWORDS;

    logic              clk;
    logic              reset;
    logic              start;
    logic [31:0]       first_index;
    logic [31:0]       count;
    logic              busy;
    logic              done;
    logic [31:0]       rd_index;
    logic              rd_read;
    logic              rd_iready;
    logic [ELEMSZ-1:0] rd_data;
    logic              rd_ovalid;
    logic [ELEMSZ-1:0] out_data;
    logic [31:0]       out_index;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    elem_streamer #(.NDWORDS(NDWORDS), .ELEMSZ(ELEMSZ), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .first_index(first_index), .count(count),
        .busy(busy), .done(done), .rd_index(rd_index), .rd_read(rd_read),
        .rd_iready(rd_iready), .rd_data(rd_data), .rd_ovalid(rd_ovalid),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Monitor state
    logic [31:0]       rd_log[$];
    logic [31:0]       out_idx_q[$];
    logic              out_last_q[$];
    logic [ELEMSZ-1:0] out_data_q[$];
    logic [31:0]       exp_q[$];
    int first_rd_cyc, first_ov_cyc, done_cyc, last_hs_cyc, done_cnt;
    bit ov_seen, done_busy;

    // Reader model
    bit rdr_auto;
    int rdr_lat;
    bit pend;
    int pend_wait;
    logic [31:0] pend_idx;

    function automatic logic [ELEMSZ-1:0] mk_data(input logic [31:0] idx);
        logic [ELEMSZ-1:0] d;
        for (int w = 0; w < NDWORDS; w++) begin
            d[32*w +: 32] = idx ^ (32'hA500_0000 + 32'(w));
        end
        return d;
    endfunction

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_read) begin
                rd_log.push_back(rd_index);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (out_valid) begin
                ov_seen = 1'b1;
                if (first_ov_cyc < 0) first_ov_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                out_idx_q.push_back(out_index);
                out_last_q.push_back(out_last);
                out_data_q.push_back(out_data);
                if (out_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    end

    // ---------------- reader driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rdr_auto) begin
                rd_ovalid = 1'b0;
                if (pend) begin
                    if (pend_wait == 0) begin
                        rd_ovalid = 1'b1;
                        rd_data   = mk_data(pend_idx);
                        pend      = 1'b0;
                    end else begin
                        pend_wait--;
                    end
                end
                if (rd_read) begin
                    pend      = 1'b1;
                    pend_idx  = rd_index;
                    pend_wait = rdr_lat - 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        rd_log.delete();
        out_idx_q.delete();
        out_last_q.delete();
        out_data_q.delete();
        exp_q.delete();
        first_rd_cyc = -1;
        first_ov_cyc = -1;
        done_cyc     = -1;
        last_hs_cyc  = -1;
        ov_seen      = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] fi, input logic [31:0] cnt, output int s);
        @(posedge clk); #1;
        start = 1'b1;
        first_index = fi;
        count = cnt;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, rd_read, out_valid, out_last} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 00000", {busy, done, rd_read, out_valid, out_last});
        end
        n_cmp++;
        if ({rd_index, out_index, out_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: rd_index=%0h out_index=%0h, required 0", rd_index, out_index);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int s, d0, k;
        bit ok;
        clear_logs();
        d0 = done_cnt;
        exp_q = '{32'd5, 32'd6, 32'd7};
        do_start(32'd5, 32'd3, s);
        wait_done(100, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_done_timeout: got %0d required 1", ok); end
        n_cmp++;
        if (first_rd_cyc !== s + 1) begin
            n_bad++; $display("FAIL basic_rd_latency: got cycle %0d required %0d", first_rd_cyc, s + 1);
        end
        n_cmp++;
        if (first_ov_cyc !== s + 3) begin
            n_bad++; $display("FAIL basic_ov_latency: got cycle %0d required %0d", first_ov_cyc, s + 3);
        end
        n_cmp++;
        if (rd_log.size() !== 3 || rd_log[0] !== 32'd5 || rd_log[1] !== 32'd6 || rd_log[2] !== 32'd7) begin
            n_bad++; $display("FAIL basic_rd_index: got %0d reads required 5,6,7", rd_log.size());
        end
        k = 0;
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (k >= out_idx_q.size() || out_idx_q[k] !== e || out_last_q[k] !== (e == 32'd7)
                || out_data_q[k] !== mk_data(e)) begin
                n_bad++; $display("FAIL basic_out[%0d]: required index %0d (last=%0d)", k, e, e == 32'd7);
            end
            k++;
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
        n_cmp++;
        if (done_cyc !== last_hs_cyc + 1) begin
            n_bad++; $display("FAIL basic_done_timing: got %0d required %0d", done_cyc, last_hs_cyc + 1);
        end
        n_cmp++;
        if (done_busy !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy_fall: got %0d/%0d required 0/0", done_busy, busy);
        end
    endtask

    task automatic test_zero_count();
        int s;
        bit ok;
        clear_logs();
        do_start(32'h100, 32'd0, s);
        wait_done(10, ok);
        n_cmp++;
        if (ok !== 1'b1 || done_cyc - s < 1 || done_cyc - s > 2) begin
            n_bad++; $display("FAIL zero_done: got delay %0d required 1..2", done_cyc - s);
        end
        n_cmp++;
        if (rd_log.size() !== 0 || ov_seen !== 1'b0) begin
            n_bad++; $display("FAIL zero_activity: got reads=%0d ov=%0d required 0/0", rd_log.size(), ov_seen);
        end
    endtask

    task automatic test_backpressure();
        int s;
        bit ok;
        clear_logs();
        out_ready = 1'b0;
        do_start(32'd20, 32'd8, s);
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_log.size() !== 4 || rd_read !== 1'b0) begin
            n_bad++; $display("FAIL bp_credit: got reads=%0d rd_read=%0d required 4/0", rd_log.size(), rd_read);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_index !== 32'd20 || out_last !== 1'b0 || out_data !== mk_data(32'd20)) begin
            n_bad++; $display("FAIL bp_hold: got valid=%0d index=%0d required 1/20", out_valid, out_index);
        end
        out_ready = 1'b1;
        wait_done(200, ok);
        n_cmp++;
        if (ok !== 1'b1 || out_idx_q.size() !== 8) begin
            n_bad++; $display("FAIL bp_drain: got %0d elements required 8", out_idx_q.size());
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(32'd20 + 32'(i));
        for (int i = 0; i < 8 && i < out_idx_q.size(); i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_idx_q[i] !== e || out_last_q[i] !== (i == 7) || out_data_q[i] !== mk_data(e)) begin
                n_bad++; $display("FAIL bp_out[%0d]: got index %0d required %0d", i, out_idx_q[i], e);
            end
        end
    endtask

    task automatic test_iready_stall();
        int s, r;
        bit ok;
        clear_logs();
        rd_iready = 1'b0;
        do_start(32'd40, 32'd1, s);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_log.size() !== 0) begin n_bad++; $display("FAIL stall_no_read: got %0d reads required 0", rd_log.size()); end
        rd_iready = 1'b1;
        r = cyc;
        wait_done(50, ok);
        n_cmp++;
        if (first_rd_cyc !== r) begin n_bad++; $display("FAIL stall_resume: got cycle %0d required %0d", first_rd_cyc, r); end
        n_cmp++;
        if (ok !== 1'b1 || out_idx_q.size() !== 1 || out_idx_q[0] !== 32'd40 || out_last_q[0] !== 1'b1) begin
            n_bad++; $display("FAIL stall_out: got %0d elements required one (40,last)", out_idx_q.size());
        end
    endtask

    task automatic test_spurious();
        int s;
        bit ok;
        clear_logs();
        rdr_auto = 1'b0;
        @(posedge clk); #1;
        rd_ovalid = 1'b1;
        rd_data = mk_data(32'd99);
        @(posedge clk); #1;
        rd_ovalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ov_seen !== 1'b0) begin n_bad++; $display("FAIL spur_idle: got out_valid=%0d required 0", ov_seen); end
        rd_iready = 1'b0;
        do_start(32'd60, 32'd1, s);
        rd_ovalid = 1'b1;
        @(posedge clk); #1;
        rd_ovalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ov_seen !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL spur_issue: got out_valid=%0d busy=%0d required 0/1", ov_seen, busy);
        end
        rdr_auto = 1'b1;
        rd_iready = 1'b1;
        wait_done(50, ok);
        n_cmp++;
        if (ok !== 1'b1 || out_idx_q.size() !== 1 || out_idx_q[0] !== 32'd60) begin
            n_bad++; $display("FAIL spur_recover: got %0d elements required one (60)", out_idx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int s, n;
        bit ok;
        clear_logs();
        rdr_lat = 3;
        do_start(32'd100, 32'd5, s);
        n = 0;
        while (rd_log.size() < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (rd_log.size() !== 2) begin n_bad++; $display("FAIL rmid_reach_wait: got %0d reads required 2", rd_log.size()); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, rd_read, out_valid, out_last, rd_index, out_index, out_data} !== '0) begin
            n_bad++; $display("FAIL rmid_outputs: got busy=%0d valid=%0d rd_index=%0h required 0", busy, out_valid, rd_index);
        end
        ov_seen = 1'b0;
        rd_log.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (ov_seen !== 1'b0 || busy !== 1'b0 || rd_log.size() !== 0) begin
            n_bad++; $display("FAIL rmid_ignore: got ov=%0d busy=%0d reads=%0d required 0/0/0", ov_seen, busy, rd_log.size());
        end
        clear_logs();
        rdr_lat = 1;
        do_start(32'hFFFF_FFFF, 32'd2, s);
        wait_done(100, ok);
        n_cmp++;
        if (ok !== 1'b1 || rd_log.size() !== 2 || rd_log[0] !== 32'hFFFF_FFFF || rd_log[1] !== 32'h0) begin
            n_bad++; $display("FAIL wrap_rd_index: got %0d reads required ffffffff,0", rd_log.size());
        end
        n_cmp++;
        if (out_idx_q.size() !== 2 || out_idx_q[0] !== 32'hFFFF_FFFF || out_idx_q[1] !== 32'h0
            || out_last_q[0] !== 1'b0 || out_last_q[1] !== 1'b1) begin
            n_bad++; $display("FAIL wrap_out: got %0d elements required ffffffff then 0(last)", out_idx_q.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        first_index = '0;
        count = '0;
        rd_iready = 1'b1;
        rd_data = '0;
        rd_ovalid = 1'b0;
        out_ready = 1'b1;
        rdr_auto = 1'b1;
        rdr_lat = 1;
        pend = 1'b0;
        pend_wait = 0;
        pend_idx = '0;
        done_cnt = 0;
        done_busy = 1'b0;
        clear_logs();

        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_iready_stall();
        test_spurious();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
